// File: rtl/adc_pkg.sv
// Shared widths and FSM encoding for the ADC sample packer.
package adc_pkg;
    localparam int CH_NUM_DEF = 8;
    localparam int SAMPLE_W   = 16;
    localparam int WORD_W     = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head word is always on dout.
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = count;
    // Gate the head so an empty FIFO presents zeros rather than stale storage.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/adc_sample_packer.sv
// Packs masked ADC channel samples pairwise into 32-bit words and streams them
// out over AXI4-Stream, closing each packet of Frame_Len conversions with tlast.
module adc_sample_packer
    import adc_pkg::*;
#(
    parameter int CH_NUM     = CH_NUM_DEF,
    parameter int FIFO_DEPTH = 64,
    parameter int FRAME_W    = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Enable,
    input  logic [CH_NUM-1:0]             Ch_Mask,
    input  logic [FRAME_W-1:0]            Frame_Len,
    input  logic [SAMPLE_W-1:0]           data_mult_ch,
    input  logic [CH_NUM-1:0]             data_flag,
    input  logic                          Conv_Done,
    output logic [WORD_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [15:0]                   Overflow_Cnt,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level
);
    state_t               state, state_nxt;
    logic [CH_NUM-1:0]    mask_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [FRAME_W-1:0]   conv_cnt;
    logic [SAMPLE_W-1:0]  low_q, low_nxt;
    logic                 odd_q, odd_nxt;
    logic                 carry_last;

    logic                 start, done, hit, frame_end;
    logic                 push, push_last;
    logic [WORD_W-1:0]    push_word;
    logic [FRAME_W:0]     frame_max;

    logic                 fifo_full, fifo_empty, fifo_pop, accept, drop, in_last;
    logic [WORD_W:0]      fifo_dout;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)               state_nxt = CAPTURE;
            CAPTURE: if (Conv_Done && !Enable) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // The start sample uses the mask being latched this cycle; the
    // last-channel sample is handled before end-of-conversion padding.
    always_comb begin
        start     = (state == IDLE) && Enable && (|Ch_Mask) && data_flag[0];
        done      = (state == CAPTURE) && Conv_Done;
        hit       = start ? |(data_flag & Ch_Mask)
                          : (state == CAPTURE) && |(data_flag & mask_q);
        low_nxt   = low_q;
        odd_nxt   = odd_q;
        push      = 1'b0;
        push_word = '0;
        if (hit) begin
            if (odd_q) begin
                push      = 1'b1;
                push_word = {data_mult_ch, low_q};
                odd_nxt   = 1'b0;
            end else begin
                low_nxt   = data_mult_ch;
                odd_nxt   = 1'b1;
            end
        end
        if (done && odd_nxt) begin
            push      = 1'b1;
            push_word = {{SAMPLE_W{1'b0}}, low_nxt};
            odd_nxt   = 1'b0;
        end
        frame_max = (frame_q == '0) ? (FRAME_W+1)'(1) : {1'b0, frame_q};
        frame_end = done && ((({1'b0, conv_cnt} + 1'b1) >= frame_max) || !Enable);
        push_last = frame_end && push;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mask_q   <= '0;
            frame_q  <= '0;
            conv_cnt <= '0;
            low_q    <= '0;
            odd_q    <= 1'b0;
        end else begin
            low_q <= low_nxt;
            odd_q <= odd_nxt;
            if (start || done) begin
                mask_q  <= Ch_Mask;
                frame_q <= Frame_Len;
            end
            if (done) conv_cnt <= frame_end ? '0 : conv_cnt + 1'b1;
        end
    end

    assign fifo_pop = !fifo_empty && m_axis_tready;
    assign accept   = push && (!fifo_full || fifo_pop);
    assign drop     = push && fifo_full && !fifo_pop;
    assign in_last  = push_last || carry_last;

    // A dropped packet terminator is carried onto the next stored word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Overflow_Cnt <= '0;
            carry_last   <= 1'b0;
        end else if (drop) begin
            if (Overflow_Cnt != 16'hFFFF) Overflow_Cnt <= Overflow_Cnt + 1'b1;
            if (in_last) carry_last <= 1'b1;
        end else if (accept) begin
            carry_last <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (accept),
        .din   ({in_last, push_word}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (Fifo_Level)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_dout[WORD_W-1:0];
    assign m_axis_tlast  = fifo_dout[WORD_W];
endmodule

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Sits directly downstream of the AD7606 conversion driver, upstream of the DDR write DMA.
- Consumes the per-channel 16-bit sample stream (one-hot channel flags plus a conversion-done pulse) and keeps only channels selected by a mask.
- Packs pairs of samples into 32-bit words and buffers them in a FIFO.
- Emits an AXI4-Stream master with tlast closing a packet of Frame_Len conversions.

Parameters:
- CH_NUM, 8, number of ADC channels; width of the flag and mask buses.
- FIFO_DEPTH, 64, FIFO depth in words; must be a power of two, at least 4.
- FRAME_W, 16, width of Frame_Len and of the internal conversion counter.

Ports:
- Clk  in  1  system clock, 100 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- Enable  in  1  capture enable; level-sensitive.
- Ch_Mask  in  CH_NUM  channel select; bit i=1 keeps channel i.
- Frame_Len  in  FRAME_W  conversions per packet; 0 is treated as 1.
- data_mult_ch  in  16  sample value; valid in the cycle its flag is high.
- data_flag  in  CH_NUM  one-hot single-cycle pulse per channel, channel 0 first.
- Conv_Done  in  1  single-cycle end-of-conversion pulse.
- m_axis_tdata  out  32  packed word; lower channel in [15:0].
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of packet.
- Overflow_Cnt  out  16  count of words dropped on FIFO full; saturates at 0xFFFF.
- Fifo_Level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: all outputs 0.
  - State returns to IDLE; the half-word holder, odd flag, conversion counter and FIFO are cleared.
  - A reset mid-conversion discards any partial word.
- Ports and polarity: one clock Clk; reset Reset_n is asynchronous and active-low.
- State machine IDLE/CAPTURE:
  - IDLE -> CAPTURE when Enable=1, Ch_Mask!=0 and data_flag[0]=1. That sample is processed in the same cycle.
  - Ch_Mask and Frame_Len are latched on this transition and again on every Conv_Done while in CAPTURE.
  - CAPTURE -> IDLE on the Conv_Done that sees Enable=0; the final word of that conversion carries tlast (short packet).
- Sample path, per cycle with data_flag[i] && mask_q[i]:
  - If the odd flag is 0: store the sample in the low holder and set odd=1.
  - If the odd flag is 1: push {sample, low} to the FIFO and set odd=0.
  - Flags on masked-out channels are ignored. Flags seen in IDLE (other than the start condition) are ignored.
- Conversion end (Conv_Done in CAPTURE):
  - If odd=1 after this cycle's sample, push {16'h0000, low} and clear odd.
  - Increment the conversion counter.
  - The word pushed at the end of the conversion is tagged last when count+1 == max(Frame_Len,1) or Enable=0; the counter then resets to 0.
  - If the conversion produced no words, nothing is tagged.
- Simultaneous data_flag[CH_NUM-1] and Conv_Done (the normal upstream timing):
  - The sample is processed first, then finalization, all in one cycle.
  - Only one FIFO push is possible: either the pair {s7, low}, or the padded word when s7 starts a new pair.
  - If s7 is masked and odd=1 → pad push.
- FIFO: 33 bits wide (last + data), first-word-fall-through.
  - A word pushed at cycle t is visible on m_axis at cycle t+1.
  - Push while full: the word is dropped and Overflow_Cnt increments. If the dropped word carried last, the next pushed word inherits last so packets stay delimited.
- AXI-Stream:
  - tvalid = FIFO not empty. A transfer occurs on tvalid && tready and pops one word.
  - tdata and tlast are held stable while tvalid && !tready.
  - Simultaneous push and pop at full: allowed, no drop.
- Throughput: one push per cycle maximum; upstream produces at most one flag per 10 cycles.

Decomposition:
- Package adc_pkg: CH_NUM default, SAMPLE_W=16, WORD_W=32, state enum {IDLE, CAPTURE}.
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH): push/pop/full/empty/level. The packer instantiates it with WIDTH=33.

Test Plan:
- Mask=0xFF, Frame_Len=1, one conversion with samples 0x1000..0x1007 and tready=1 → words 0x10011000, 0x10031002, 0x10051004, 0x10071006; tlast only on the 4th.
- Mask=0x07, Frame_Len=2, two conversions of 0x1000.. → 0x10011000, 0x00001002, 0x10011000, 0x00001002; tlast on the 4th only.
- Mask=0x80, flag[7] coincident with Conv_Done, sample 0xABCD, Frame_Len=1 → single word 0x0000ABCD with tlast.
- tready=0, Mask=0xFF:
  - After 16 conversions Fifo_Level=64; the next conversion drops 4 words and Overflow_Cnt=4.
  - Head tdata is stable throughout.
  - With tready=1 the 64 words drain in order.
- Frame_Len=4, Enable deasserted during conversion 2 → tlast on the last word of conversion 2, then IDLE; later flags produce no words until Enable=1 and flag[0].
- Reset_n pulsed low after flag[2] with Mask=0xFF → all outputs 0 immediately; after release, a fresh conversion yields exactly 4 correct words.
